// File: rtl/conv_stream_pkg.sv
// Shared types and elaboration helpers for the streaming convolution engine.
package conv_stream_pkg;

  typedef enum logic [2:0] {
    LOAD_F  = 3'd0,
    LOAD_X  = 3'd1,
    COMPUTE = 3'd2,
    DRAIN   = 3'd3,
    IDLE    = 3'd4
  } state_e;

  function automatic longint sat_max(input int unsigned t);
    return (longint'(1) <<< (t - 1)) - longint'(1);
  endfunction

  function automatic longint sat_min(input int unsigned t);
    return -(longint'(1) <<< (t - 1));
  endfunction

  // ceil((n-m+1)/p): number of lane groups needed to cover every output
  function automatic int unsigned num_groups(input int unsigned n, input int unsigned m,
                                             input int unsigned p);
    return (n - m + p) / p;
  endfunction

  function automatic int unsigned addr_w(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/sat_mac_lane.sv
// One pipelined saturating MAC lane: input register, product register, accumulator.
// The final sum is exposed combinationally so the result bank captures it on the last accumulate.
module sat_mac_lane import conv_stream_pkg::*; #(
  parameter int unsigned T = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_stall,
  input  logic         i_vld,
  input  logic         i_clr,
  input  logic         i_last,
  input  logic [T-1:0] i_x,
  input  logic [T-1:0] i_f,
  output logic [T-1:0] o_sum_c,
  output logic         o_done_c
);

  localparam int unsigned PW = 2 * T;
  localparam int unsigned AW = T + 1;
  localparam logic signed [T-1:0] SMAX = T'(sat_max(T));
  localparam logic signed [T-1:0] SMIN = T'(sat_min(T));

  logic signed [T-1:0]  r_x, r_f, r_prod, r_acc;
  logic                 r_v1, r_clr1, r_last1, r_v2, r_clr2, r_last2;
  logic signed [PW-1:0] w_full;
  logic signed [AW-1:0] w_add;
  logic signed [T-1:0]  w_prod_sat, w_acc_nxt;

  always_comb begin
    w_full = PW'(r_x) * PW'(r_f);
    if (w_full > PW'(SMAX))      w_prod_sat = SMAX;
    else if (w_full < PW'(SMIN)) w_prod_sat = SMIN;
    else                         w_prod_sat = T'(w_full);

    // first tap of a group restarts the sum instead of adding to the old one
    w_add = AW'(r_acc) + AW'(r_prod);
    if (r_clr2)                  w_acc_nxt = r_prod;
    else if (w_add > AW'(SMAX))  w_acc_nxt = SMAX;
    else if (w_add < AW'(SMIN))  w_acc_nxt = SMIN;
    else                         w_acc_nxt = T'(w_add);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_x <= '0; r_f <= '0; r_prod <= '0; r_acc <= '0;
      r_v1 <= 1'b0; r_clr1 <= 1'b0; r_last1 <= 1'b0;
      r_v2 <= 1'b0; r_clr2 <= 1'b0; r_last2 <= 1'b0;
    end else if (!i_stall) begin
      r_x     <= i_x;
      r_f     <= i_f;
      r_v1    <= i_vld;
      r_clr1  <= i_clr;
      r_last1 <= i_last;
      r_prod  <= w_prod_sat;
      r_v2    <= r_v1;
      r_clr2  <= r_clr1;
      r_last2 <= r_last1;
      if (r_v2) r_acc <= w_acc_nxt;
    end
  end

  assign o_sum_c  = w_acc_nxt;
  assign o_done_c = r_v2 & r_last2;

endmodule

// File: rtl/sp_ram.sv
// Single-port synchronous RAM: write or registered read when enabled, output holds otherwise.
module sp_ram import conv_stream_pkg::*; #(
  parameter int unsigned W  = 16,
  parameter int unsigned D  = 8,
  parameter int unsigned AW = addr_w(D)
) (
  input  logic          clk,
  input  logic          i_en,
  input  logic          i_we,
  input  logic [AW-1:0] i_addr,
  input  logic [W-1:0]  i_wdata,
  output logic [W-1:0]  o_rdata
);

  logic [W-1:0] r_mem [D];

  always_ff @(posedge clk) begin
    if (i_en) begin
      if (i_we) r_mem[i_addr] <= i_wdata;
      else      o_rdata       <= r_mem[i_addr];
    end
  end

endmodule

// File: rtl/conv_stream_par.sv
// Streaming 1-D valid convolution with reloadable filter, P saturating MAC lanes,
// optional ReLU and an in-order valid/ready result stream.
module conv_stream_par import conv_stream_pkg::*; #(
  parameter int unsigned T    = 16,
  parameter int unsigned N    = 96,
  parameter int unsigned M    = 65,
  parameter int unsigned P    = 4,
  parameter int unsigned RELU = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [T-1:0] f_data,
  input  logic         f_valid,
  output logic         f_ready,
  input  logic [T-1:0] x_data,
  input  logic         x_valid,
  output logic         x_ready,
  output logic [T-1:0] y_data,
  output logic         y_valid,
  input  logic         y_ready
);

  localparam int unsigned NY       = N - M + 1;
  localparam int unsigned G        = num_groups(N, M, P);
  localparam int unsigned LAST_ACT = NY - (G - 1) * P;
  localparam int unsigned XW       = addr_w(N);
  localparam int unsigned FW       = addr_w(M);
  localparam int unsigned GW       = addr_w(G + 1);
  localparam int unsigned CW       = addr_w(N + P + M);
  localparam int unsigned CNTW     = addr_w(P + 1);

  state_e          r_state, w_state_nxt;
  logic [FW-1:0]   r_fcnt, w_fcnt_nxt, r_tap, w_tap_nxt;
  logic [XW-1:0]   r_xcnt, w_xcnt_nxt;
  logic [GW-1:0]   r_grp, w_grp_nxt, r_wr_grp;
  logic [CW-1:0]   r_base, w_base_nxt;
  logic            w_f_xfer, w_x_xfer, w_y_xfer, w_issue, w_stall, w_bank_wr;
  logic            r_rd_vld, r_rd_first, r_rd_last;
  logic [T-1:0]    w_f_rd;
  logic [T-1:0]    w_sum [P];
  logic [P-1:0]    w_done;
  logic [T-1:0]    r_bank [P];
  logic [CNTW-1:0] r_cnt;
  logic            r_y_valid;

  // ready is a decode of the registered state; in IDLE the filter wins a tie
  always_comb begin
    w_state_nxt = r_state;
    w_fcnt_nxt  = r_fcnt;
    w_xcnt_nxt  = r_xcnt;
    w_tap_nxt   = r_tap;
    w_grp_nxt   = r_grp;
    w_base_nxt  = r_base;
    f_ready     = 1'b0;
    x_ready     = 1'b0;
    w_issue     = 1'b0;
    case (r_state)
      LOAD_F:  f_ready = 1'b1;
      LOAD_X:  x_ready = 1'b1;
      COMPUTE: w_issue = !w_stall;
      IDLE: begin
        f_ready = 1'b1;
        x_ready = !f_valid;
      end
      default: ;
    endcase
    w_f_xfer = f_valid & f_ready;
    w_x_xfer = x_valid & x_ready;

    if (w_f_xfer) begin
      if (r_fcnt == FW'(M - 1)) begin
        w_fcnt_nxt  = '0;
        w_state_nxt = LOAD_X;
      end else begin
        w_fcnt_nxt  = r_fcnt + 1'b1;
        w_state_nxt = LOAD_F;
      end
    end
    if (w_x_xfer) begin
      if (r_xcnt == XW'(N - 1)) begin
        w_xcnt_nxt  = '0;
        w_tap_nxt   = '0;
        w_grp_nxt   = '0;
        w_base_nxt  = '0;
        w_state_nxt = COMPUTE;
      end else begin
        w_xcnt_nxt  = r_xcnt + 1'b1;
        w_state_nxt = LOAD_X;
      end
    end
    if (w_issue) begin
      if (r_tap == FW'(M - 1)) begin
        w_tap_nxt = '0;
        if (r_grp == GW'(G - 1)) begin
          w_state_nxt = DRAIN;
        end else begin
          w_grp_nxt  = r_grp + 1'b1;
          w_base_nxt = r_base + CW'(P);
        end
      end else begin
        w_tap_nxt = r_tap + 1'b1;
      end
    end
    if (r_state == DRAIN && r_wr_grp == GW'(G) && r_cnt == '0) w_state_nxt = IDLE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= LOAD_F;
      r_fcnt  <= '0;
      r_xcnt  <= '0;
      r_tap   <= '0;
      r_grp   <= '0;
      r_base  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_fcnt  <= w_fcnt_nxt;
      r_xcnt  <= w_xcnt_nxt;
      r_tap   <= w_tap_nxt;
      r_grp   <= w_grp_nxt;
      r_base  <= w_base_nxt;
    end
  end

  // tap flags travel alongside the one-cycle memory read
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_vld   <= 1'b0;
      r_rd_first <= 1'b0;
      r_rd_last  <= 1'b0;
    end else if (!w_stall) begin
      r_rd_vld   <= w_issue;
      r_rd_first <= (r_tap == '0);
      r_rd_last  <= (r_tap == FW'(M - 1));
    end
  end

  sp_ram #(.W(T), .D(M)) u_f_mem (
    .clk     (clk),
    .i_en    (w_f_xfer | !w_stall),
    .i_we    (w_f_xfer),
    .i_addr  (w_f_xfer ? r_fcnt : r_tap),
    .i_wdata (f_data),
    .o_rdata (w_f_rd)
  );

  for (genvar p = 0; p < P; p++) begin : g_lane
    logic [CW-1:0] w_pos;
    logic [XW-1:0] w_x_addr;
    logic [T-1:0]  w_x_rd;

    // inactive lanes of the last group read a safe address; their sums are never emitted
    always_comb begin
      w_pos    = r_base + CW'(p);
      w_x_addr = '0;
      if (w_x_xfer)                  w_x_addr = r_xcnt;
      else if (w_pos <= CW'(N - M))  w_x_addr = XW'(w_pos + CW'(r_tap));
    end

    sp_ram #(.W(T), .D(N)) u_x_mem (
      .clk     (clk),
      .i_en    (w_x_xfer | !w_stall),
      .i_we    (w_x_xfer),
      .i_addr  (w_x_addr),
      .i_wdata (x_data),
      .o_rdata (w_x_rd)
    );

    sat_mac_lane #(.T(T)) u_lane (
      .clk      (clk),
      .reset    (reset),
      .i_stall  (w_stall),
      .i_vld    (r_rd_vld),
      .i_clr    (r_rd_first),
      .i_last   (r_rd_last),
      .i_x      (w_x_rd),
      .i_f      (w_f_rd),
      .o_sum_c  (w_sum[p]),
      .o_done_c (w_done[p])
    );
  end

  // a finished group waits in the lanes until the previous group has fully drained
  assign w_stall   = (&w_done) && (r_cnt != '0);
  assign w_bank_wr = (&w_done) && (r_cnt == '0);
  assign w_y_xfer  = r_y_valid & y_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < P; i++) r_bank[i] <= '0;
      r_cnt     <= '0;
      r_y_valid <= 1'b0;
      r_wr_grp  <= '0;
    end else begin
      if (w_x_xfer && r_xcnt == XW'(N - 1)) r_wr_grp <= '0;
      if (w_bank_wr) begin
        for (int i = 0; i < P; i++)
          r_bank[i] <= (RELU != 0 && w_sum[i][T-1]) ? '0 : w_sum[i];
        r_cnt     <= (r_wr_grp == GW'(G - 1)) ? CNTW'(LAST_ACT) : CNTW'(P);
        r_y_valid <= 1'b1;
        r_wr_grp  <= r_wr_grp + 1'b1;
      end else if (w_y_xfer) begin
        for (int i = 0; i < P - 1; i++) r_bank[i] <= r_bank[i+1];
        r_cnt     <= r_cnt - 1'b1;
        r_y_valid <= (r_cnt != CNTW'(1));
      end
    end
  end

  assign y_data  = r_bank[0];
  assign y_valid = r_y_valid;

endmodule

// File: tb/tb_conv_stream_par.sv
// Directed bench: instance 0 is N=8,M=3,P=2,RELU=1; instance 1 is N=8,M=4,P=2,RELU=0.
module tb_conv_stream_par;

  logic        clk;
  logic        rst     [2];
  logic [15:0] f_data  [2];
  logic [15:0] x_data  [2];
  logic [15:0] y_data  [2];
  logic        f_valid [2];
  logic        f_ready [2];
  logic        x_valid [2];
  logic        x_ready [2];
  logic        y_valid [2];
  logic        y_ready [2];

  int n_chk;
  int n_fail;
  int q_ramp1[$], q_ramp2[$], q_max[$], q_exp[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  conv_stream_par #(.T(16), .N(8), .M(3), .P(2), .RELU(1)) u_a (
    .clk(clk), .reset(rst[0]),
    .f_data(f_data[0]), .f_valid(f_valid[0]), .f_ready(f_ready[0]),
    .x_data(x_data[0]), .x_valid(x_valid[0]), .x_ready(x_ready[0]),
    .y_data(y_data[0]), .y_valid(y_valid[0]), .y_ready(y_ready[0])
  );

  conv_stream_par #(.T(16), .N(8), .M(4), .P(2), .RELU(0)) u_b (
    .clk(clk), .reset(rst[1]),
    .f_data(f_data[1]), .f_valid(f_valid[1]), .f_ready(f_ready[1]),
    .x_data(x_data[1]), .x_valid(x_valid[1]), .x_ready(x_ready[1]),
    .y_data(y_data[1]), .y_valid(y_valid[1]), .y_ready(y_ready[1])
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic void fill(output int q[$], input int n, input int v0, input int step);
    q = {};
    for (int i = 0; i < n; i++) q.push_back(v0 + i * step);
  endfunction

  task automatic push_f(input int u, input int v);
    bit done = 1'b0;
    f_data[u]  = 16'(v);
    f_valid[u] = 1'b1;
    for (int c = 0; c < 50 && !done; c++) begin
      @(negedge clk);
      done = f_ready[u];
      @(posedge clk); #1;
    end
    f_valid[u] = 1'b0;
    chk("f_accept", int'(done), 1);
  endtask

  task automatic push_x(input int u, input int v);
    bit done = 1'b0;
    x_data[u]  = 16'(v);
    x_valid[u] = 1'b1;
    for (int c = 0; c < 50 && !done; c++) begin
      @(negedge clk);
      done = x_ready[u];
      @(posedge clk); #1;
    end
    x_valid[u] = 1'b0;
    chk("x_accept", int'(done), 1);
  endtask

  task automatic load_f(input int u, input int v[$]);
    foreach (v[i]) push_f(u, v[i]);
  endtask

  task automatic load_x(input int u, input int v[$]);
    foreach (v[i]) push_x(u, v[i]);
  endtask

  // mode 0: always ready; mode 1: ready one cycle in three
  task automatic collect(input int u, input string tag, input int exp[$], input int mode);
    int k = 0;
    int cyc = 0;
    int extra = 0;
    while (k < exp.size() && cyc < 2000) begin
      y_ready[u] = (mode == 0) || (cyc % 3 == 0);
      @(negedge clk);
      if (y_valid[u]) begin
        if (y_ready[u]) begin
          chk(tag, int'($signed(y_data[u])), exp[k]);
          k++;
        end else begin
          chk({tag, "_hold"}, int'($signed(y_data[u])), exp[k]);
        end
      end
      @(posedge clk); #1;
      cyc++;
    end
    chk({tag, "_count"}, k, exp.size());
    y_ready[u] = 1'b1;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (y_valid[u]) extra++;
      @(posedge clk); #1;
    end
    chk({tag, "_extra"}, extra, 0);
    y_ready[u] = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int c;
    n_chk  = 0;
    n_fail = 0;
    fill(q_ramp1, 8, 1, 1);
    fill(q_ramp2, 8, 2, 1);
    fill(q_max, 8, 32767, 0);
    for (int u = 0; u < 2; u++) begin
      rst[u] = 1'b1; f_valid[u] = 1'b0; x_valid[u] = 1'b0; y_ready[u] = 1'b0;
      f_data[u] = '0; x_data[u] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    rst[0] = 1'b0;
    rst[1] = 1'b0;
    @(negedge clk);
    for (int u = 0; u < 2; u++) begin
      chk("rst_f_ready", int'(f_ready[u]), 1);
      chk("rst_x_ready", int'(x_ready[u]), 0);
      chk("rst_y_valid", int'(y_valid[u]), 0);
      chk("rst_y_data", int'(y_data[u]), 0);
    end
    @(posedge clk); #1;

    // instance 0: basic, back-to-back, reload with f/x tie, saturation, backpressure, reset
    load_f(0, '{1, 1, 1});
    load_x(0, q_ramp1);
    q_exp = '{6, 9, 12, 15, 18, 21};
    collect(0, "a_basic", q_exp, 0);
    @(negedge clk);
    chk("a_idle_f_ready", int'(f_ready[0]), 1);
    chk("a_idle_x_ready", int'(x_ready[0]), 1);
    @(posedge clk); #1;

    load_x(0, q_ramp2);
    q_exp = '{9, 12, 15, 18, 21, 24};
    collect(0, "a_b2b", q_exp, 0);

    f_data[0] = 16'd2; f_valid[0] = 1'b1;
    x_data[0] = 16'd99; x_valid[0] = 1'b1;
    @(negedge clk);
    chk("a_tie_x_ready", int'(x_ready[0]), 0);
    chk("a_tie_f_ready", int'(f_ready[0]), 1);
    @(posedge clk); #1;
    f_valid[0] = 1'b0;
    x_valid[0] = 1'b0;
    load_f(0, '{0, 0});
    load_x(0, q_ramp1);
    q_exp = '{2, 4, 6, 8, 10, 12};
    collect(0, "a_reload", q_exp, 0);

    load_f(0, '{2, 2, 2});
    load_x(0, q_max);
    fill(q_exp, 6, 32767, 0);
    collect(0, "a_sat_pos", q_exp, 0);

    load_f(0, '{-2, -2, -2});
    load_x(0, q_max);
    fill(q_exp, 6, 0, 0);
    collect(0, "a_sat_relu", q_exp, 0);

    load_f(0, '{1, 1, 1});
    load_x(0, q_ramp1);
    q_exp = '{6, 9, 12, 15, 18, 21};
    collect(0, "a_bp", q_exp, 1);

    load_f(0, '{1, 1, 1});
    load_x(0, q_ramp1);
    c = 0;
    @(negedge clk);
    while (!y_valid[0] && c < 100) begin
      @(negedge clk);
      c++;
    end
    chk("a_pre_rst_valid", int'(y_valid[0]), 1);
    @(posedge clk); #1;
    rst[0] = 1'b1;
    @(posedge clk); #1;
    rst[0] = 1'b0;
    @(negedge clk);
    chk("a_mid_rst_y_valid", int'(y_valid[0]), 0);
    chk("a_mid_rst_f_ready", int'(f_ready[0]), 1);
    chk("a_mid_rst_x_ready", int'(x_ready[0]), 0);
    @(posedge clk); #1;
    load_f(0, '{1, 1, 1});
    load_x(0, q_ramp1);
    q_exp = '{6, 9, 12, 15, 18, 21};
    collect(0, "a_after_rst", q_exp, 0);

    // instance 1: partial last group and signed saturation without ReLU
    load_f(1, '{1, 0, 0, 1});
    load_x(1, q_ramp1);
    q_exp = '{5, 7, 9, 11, 13};
    collect(1, "b_partial", q_exp, 0);

    load_f(1, '{-2, -2, -2, -2});
    load_x(1, q_max);
    fill(q_exp, 5, -32768, 0);
    collect(1, "b_sat_neg", q_exp, 0);

    load_f(1, '{2, 2, 2, 2});
    load_x(1, q_max);
    fill(q_exp, 5, 32767, 0);
    collect(1, "b_sat_pos", q_exp, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
